// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared NEC protocol definitions.
//   nec_tx_state_t   transmitter state encoding
//   *_T              segment lengths in NEC units T
//   is_mark()        1 for states that radiate the carrier
//   state_last_unit() segment length minus one, loaded into the T down-counter
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_REP_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_GAP
  } nec_tx_state_t;

  localparam int LEAD_MARK_T  = 16;
  localparam int LEAD_SPACE_T = 8;
  localparam int REP_SPACE_T  = 4;
  localparam int BIT0_SPACE_T = 1;
  localparam int BIT1_SPACE_T = 3;
  localparam int MARK_T       = 1;

  function automatic logic is_mark(nec_tx_state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

  // bit1 selects the long space; only meaningful for ST_BIT_SPACE.
  function automatic logic [3:0] state_last_unit(nec_tx_state_t s, logic bit1);
    case (s)
      ST_LEAD_MARK:  return 4'(LEAD_MARK_T - 1);
      ST_LEAD_SPACE: return 4'(LEAD_SPACE_T - 1);
      ST_REP_SPACE:  return 4'(REP_SPACE_T - 1);
      ST_BIT_MARK,
      ST_STOP_MARK:  return 4'(MARK_T - 1);
      ST_BIT_SPACE:  return bit1 ? 4'(BIT1_SPACE_T - 1) : 4'(BIT0_SPACE_T - 1);
      default:       return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: ~38 kHz carrier counter.
//   iCLK, iRST_n  clock / async active-low reset
//   iRESTART      hold the count at 0 (asserted whenever not in a mark)
//   oCARRIER      carrier level for the coming cycle (count after this edge < CARRIER_HIGH),
//                 so the caller can register it straight into its output flop
module ir_carrier_gen #(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iRESTART,
  output logic oCARRIER
);
  localparam int CW = $clog2(CARRIER_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (iRESTART || (cnt_q == CW'(CARRIER_DIV - 1))) cnt_d = '0;
  end

  assign oCARRIER = (cnt_d < CW'(CARRIER_HIGH));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ir_nec_transmit.sv
// ir_nec_transmit: NEC infrared frame transmitter.
//   iCLK, iRST_n      clock / async active-low reset
//   iVALID/oREADY     request handshake; transfer when both high at a rising edge (IDLE only)
//   iDATA             32-bit payload, LSB first; iREPEAT selects the repeat code instead
//   oIRDA             registered carrier-modulated output (inverted when ACTIVE_LOW)
//   oBUSY             high from transfer until the frame slot has elapsed
//   oDONE             one-cycle pulse in the first gap cycle after the stop mark
module ir_nec_transmit
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439,
  parameter int FRAME_UNITS  = 192,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iVALID,
  output logic        oREADY,
  input  logic [31:0] iDATA,
  input  logic        iREPEAT,
  output logic        oIRDA,
  output logic        oBUSY,
  output logic        oDONE
);
  localparam int             UW        = $clog2(UNIT_CYCLES);
  localparam logic [UW-1:0]  UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0]  UNIT_PRE  = UW'(UNIT_CYCLES - 2);
  localparam logic [7:0]     FRM_LAST  = 8'(FRAME_UNITS - 1);
  localparam logic           IDLE_LVL  = (ACTIVE_LOW != 0);

  nec_tx_state_t state_q, state_d;
  logic [UW-1:0] unit_q, unit_d;
  logic [3:0]    tleft_q, tleft_d;
  logic [7:0]    frm_q, frm_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d;
  logic          rep_q, rep_d;
  logic          irda_q, irda_d;
  logic          done_q, done_d;
  logic          carrier, unit_wrap, t_end;

  ir_carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .CARRIER_HIGH(CARRIER_HIGH)
  ) u_carrier (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iRESTART(!is_mark(state_q)),
    .oCARRIER(carrier)
  );

  // State register and datapath flops
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      unit_q  <= '0;
      tleft_q <= '0;
      frm_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rep_q   <= 1'b0;
      irda_q  <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      tleft_q <= tleft_d;
      frm_q   <= frm_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rep_q   <= rep_d;
      irda_q  <= irda_d;
      done_q  <= done_d;
    end
  end

  // Next state. The unit counter free-runs from leader start so every segment
  // and the frame-slot count share one T grid.
  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    tleft_d   = tleft_q;
    frm_d     = frm_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rep_d     = rep_q;
    unit_wrap = (unit_q == UNIT_LAST);
    t_end     = unit_wrap && (tleft_q == 4'd0);

    if (state_q != ST_IDLE) begin
      unit_d = unit_wrap ? '0 : unit_q + 1'b1;
      if (unit_wrap && (frm_q != 8'hFF)) frm_d   = frm_q + 8'd1;
      if (unit_wrap && (tleft_q != 4'd0)) tleft_d = tleft_q - 4'd1;
    end

    case (state_q)
      ST_IDLE: if (iVALID) begin
        state_d = ST_LEAD_MARK;
        unit_d  = '0;
        frm_d   = '0;
        bit_d   = '0;
        sh_d    = iDATA;
        rep_d   = iREPEAT;
      end
      ST_LEAD_MARK:  if (t_end) state_d = rep_q ? ST_REP_SPACE : ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (t_end) state_d = ST_BIT_MARK;
      ST_REP_SPACE:  if (t_end) state_d = ST_STOP_MARK;
      ST_BIT_MARK:   if (t_end) state_d = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (t_end) begin
        sh_d    = sh_q >> 1;
        bit_d   = bit_q + 5'd1;
        state_d = (bit_q == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      end
      ST_STOP_MARK:  if (t_end) state_d = ST_GAP;
      // Leave one cycle before the slot ends so a held iVALID transfers on the
      // edge that completes FRAME_UNITS*T from the previous leader.
      ST_GAP: if ((frm_q == FRM_LAST) && (unit_q == UNIT_PRE)) begin
        state_d = ST_IDLE;
        unit_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) tleft_d = state_last_unit(state_d, sh_q[0]);
  end

  // Outputs
  always_comb begin
    irda_d = IDLE_LVL ^ (is_mark(state_d) & carrier);
    done_d = (state_d == ST_GAP) && (state_q != ST_GAP);
  end

  assign oIRDA  = irda_q;
  assign oDONE  = done_q;
  assign oREADY = (state_q == ST_IDLE);
  assign oBUSY  = (state_q != ST_IDLE);
endmodule
